// File: rtl/serial_word_adder_ctrl.sv
// serial_word_adder_ctrl: drives an external 8-bit combinational adder one byte per clock.
//   It adds two WIDTH-bit operands LSB byte first and feeds the adder's carry-out back as the next carry-in.
// Latency: start accepted at E0, bytes captured at E1..E_BYTES, and oDone pulses for one cycle after E_BYTES.
// Backpressure: none. iStart is only sampled in IDLE, and a request that arrives in RUN or DONE is dropped.
//
// Ports:
//   iClk, iRst_n            clock (rising edge) and asynchronous active-low reset
//   iStart, iOp_a/b, iCin   request and its operands, captured when iStart is accepted
//   oAdd_a/b/c              byte operands and carry to the adder, 0 outside RUN
//   iAdd_sum, iAdd_c        adder result for the current byte, consumed in the same cycle
//   oSum, oCout, oOvf       registered result, updated only on the RUN->DONE edge
//   oBusy, oDone            high in RUN; one-cycle result-valid pulse
//
// Optional: define SERIAL_ADD_OVF_EN to build signed-overflow detection on oOvf.
//   Without it, oOvf is tied to 0.
module serial_word_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iOp_a,
  input  logic [WIDTH-1:0] iOp_b,
  input  logic             iCin,
  output logic [7:0]       oAdd_a,
  output logic [7:0]       oAdd_b,
  output logic             oAdd_c,
  input  logic [7:0]       iAdd_sum,
  input  logic             iAdd_c,
  output logic [WIDTH-1:0] oSum,
  output logic             oCout,
  output logic             oOvf,
  output logic             oBusy,
  output logic             oDone
);

  localparam int BYTES = WIDTH / 8;
  // Keep the counter at least one bit wide so that the single-byte case still elaborates.
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_shift;

  // The incoming sum byte enters at the top of the result register.
  // After BYTES shifts, the first byte has reached bits [7:0].
  generate
    if (BYTES == 1) begin : g_res_one
      assign res_shift = iAdd_sum;
    end else begin : g_res_many
      assign res_shift = {iAdd_sum, res_q[WIDTH-1:8]};
    end
  endgenerate

`ifdef SERIAL_ADD_OVF_EN
  logic sa_q, sa_d;
  logic sb_q, sb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    sa_d    = sa_q;
    sb_d    = sb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_RUN;
          a_sh_d  = iOp_a;
          b_sh_d  = iOp_b;
          carry_d = iCin;
          cnt_d   = '0;
          res_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
          sa_d    = iOp_a[WIDTH-1];
          sb_d    = iOp_b[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        res_d   = res_shift;
        carry_d = iAdd_c;
        a_sh_d  = a_sh_q >> 8;
        b_sh_d  = b_sh_q >> 8;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // This edge captures the top byte, so the result is complete.
          state_d = S_DONE;
          sum_d   = res_shift;
          cout_d  = iAdd_c;
`ifdef SERIAL_ADD_OVF_EN
          // Signed overflow: the operands share a sign and the sum's sign differs from it.
          ovf_d   = (sa_q == sb_q) && (iAdd_sum[7] != sa_q);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      ovf_q <= ovf_d;
    end
  end
  assign oOvf = ovf_q;
`else
  assign oOvf = 1'b0;
`endif

  logic in_run;
  assign in_run = (state_q == S_RUN);

  // Adder operands are forced to 0 outside RUN.
  // The external adder therefore sees a quiet input while idle.
  assign oAdd_a = in_run ? a_sh_q[7:0] : 8'h00;
  assign oAdd_b = in_run ? b_sh_q[7:0] : 8'h00;
  assign oAdd_c = in_run & carry_q;

  assign oSum  = sum_q;
  assign oCout = cout_q;
  assign oBusy = in_run;
  assign oDone = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_word_adder_ctrl.sv
module tb_serial_word_adder_ctrl;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

`ifdef SERIAL_ADD_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        cin = 1'b0;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_c, add_co;
  logic [31:0] sum;
  logic        cout, ovf, busy, done;

  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int done_seen = 0;
  res_t exp_q[$];
  logic [31:0] last_sum = '0;
  logic        last_cout = 1'b0;
  logic        last_ovf = 1'b0;

  always #5 clk = ~clk;

  // Behavioural model of the external 8-bit adder.
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_c};

  serial_word_adder_ctrl #(.WIDTH(32)) dut (
    .iClk(clk), .iRst_n(rst_n), .iStart(start),
    .iOp_a(op_a), .iOp_b(op_b), .iCin(cin),
    .oAdd_a(add_a), .oAdd_b(add_b), .oAdd_c(add_c),
    .iAdd_sum(add_sum), .iAdd_c(add_co),
    .oSum(sum), .oCout(cout), .oOvf(ovf), .oBusy(busy), .oDone(done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every oDone pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done actual=sum %h required=no pulse", sum);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        if ({sum, cout, ovf} !== e) begin
          failures++;
          $display("FAIL result actual=%h/%b/%b required=%h/%b/%b",
                   sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
      end
    end
  end

  // One operation.
  // cmask bit i is the hand-computed oAdd_c value in RUN cycle i.
  // When inject is set, iStart is also pulsed in the first RUN cycle and in DONE, and both requests must be ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [31:0] es, input logic ec, input logic eo,
                        input logic [3:0] cmask, input bit inject);
    logic [31:0] ta, tb_;
    res_t e;
    @(negedge clk);
    op_a = a; op_b = b; cin = c; start = 1'b1;
    e.sum = es; e.cout = ec; e.ovf = eo;
    exp_q.push_back(e);
    pushed++;
    @(posedge clk); #1;
    start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_F00D; cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ta = a >> (8 * i);
      tb_ = b >> (8 * i);
      check($sformatf("busy_run%0d", i), 64'(busy), 64'(1));
      check($sformatf("done_run%0d", i), 64'(done), 64'(0));
      check($sformatf("add_a_run%0d", i), 64'(add_a), 64'(ta[7:0]));
      check($sformatf("add_b_run%0d", i), 64'(add_b), 64'(tb_[7:0]));
      check($sformatf("add_c_run%0d", i), 64'(add_c), 64'(cmask[i]));
      check($sformatf("sum_hold_run%0d", i), 64'({sum, cout, ovf}),
            64'({last_sum, last_cout, last_ovf}));
      if (inject && i == 0) begin
        start = 1'b1; op_a = 32'h5555_5555; op_b = 32'h5555_5555;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(1));
    check("busy_in_done", 64'(busy), 64'(0));
    check("add_idle_in_done", 64'({add_a, add_b, add_c}), 64'(0));
    if (inject) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
    check("busy_after", 64'(busy), 64'(0));
    check("sum_after", 64'({sum, cout, ovf}), 64'({es, ec, eo}));
    last_sum = es; last_cout = ec; last_ovf = eo;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({sum, cout, ovf, busy, done}), 64'(0));
    check("reset_adder_if", 64'({add_a, add_b, add_c}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1. basic add
    run_op(32'h0000_000D, 32'h0000_0002, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 4'b0000, 1'b0);
    // 2. carry crosses a byte boundary
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 4'b0010, 1'b0);
    // 3. carry-in ripples through all four bytes
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 4'b1111, 1'b0);
    // 4. start requests while busy are ignored
    run_op(32'h0000_000B, 32'h0000_000B, 1'b1, 32'h0000_0017, 1'b0, 1'b0, 4'b0001, 1'b1);

    // 5. reset in the middle of an operation
    @(negedge clk);
    op_a = 32'h1234_5678; op_b = 32'h1111_1111; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_done", 64'(done), 64'(0));
    check("rst_mid_sum", 64'({sum, cout, ovf}), 64'(0));
    check("rst_mid_adder_if", 64'({add_a, add_b, add_c}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_done", 64'({busy, done}), 64'(0));
    run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 4'b0000, 1'b0);

    // 6. signed overflow
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, OVF_ON, 4'b1110, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    check("done_pulse_count", 64'(done_seen), 64'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_word_adder_ctrl.md
Name: serial_word_adder_ctrl

Overview:
Multi-byte sequencer wrapped around the existing 8-bit combinational Adder. It feeds a WIDTH-bit operand pair through the Adder one byte per clock, LSB byte first, and registers the Adder's carry-out back into its carry-in. It collects the sum bytes into a WIDTH-bit result and a final carry. The Adder instance is external; this block drives its operand and carry inputs and consumes its sum and carry outputs in the same cycle.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 8 and at least 8.
BYTES, WIDTH/8, derived localparam: number of RUN cycles per operation.

Ports:
iClk  input  1  clock, rising edge.
iRst_n  input  1  asynchronous reset, active-low.
iStart  input  1  single-cycle request; sampled only in IDLE.
iOp_a  input  WIDTH  operand A; latched when iStart is accepted.
iOp_b  input  WIDTH  operand B; latched when iStart is accepted.
iCin  input  1  initial carry-in; latched when iStart is accepted.
oAdd_a  output  8  to Adder iData_a: current byte of A.
oAdd_b  output  8  to Adder iData_b: current byte of B.
oAdd_c  output  1  to Adder iC: registered carry.
iAdd_sum  input  8  from Adder oData.
iAdd_c  input  1  from Adder oData_C.
oSum  output  WIDTH  result; holds its value until the next accepted start.
oCout  output  1  final carry-out.
oOvf  output  1  signed overflow (see Optional Feature).
oBusy  output  1  high in RUN.
oDone  output  1  one-cycle pulse when the result is valid.

Behaviour:
- Clock and reset: single clock iClk. iRst_n is asynchronous and active-low. The clock and reset names and polarity are fixed.
- Reset: state=IDLE; operand, result and carry registers cleared. oSum=0, oCout=0, oOvf=0, oBusy=0, oDone=0, oAdd_a/b/c=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on iStart=1:
  - latch a_sh<=iOp_a, b_sh<=iOp_b, carry<=iCin;
  - byte counter cnt<=0; sign bits of iOp_a and iOp_b saved.
- RUN, combinational outputs: oAdd_a=a_sh[7:0], oAdd_b=b_sh[7:0], oAdd_c=carry.
- RUN, each clock edge:
  - result register shifts right by 8, with iAdd_sum entering at bits [WIDTH-1:WIDTH-8];
  - carry<=iAdd_c;
  - a_sh and b_sh shift right by 8;
  - cnt++.
- RUN -> DONE on the edge where cnt==BYTES-1, i.e. the edge that captures the last byte. On that edge: oSum<=final result, oCout<=iAdd_c.
- DONE: oDone=1 for exactly one cycle, then -> IDLE unconditionally.
- Latency: start sampled at edge E0. Bytes are captured at E1..E_BYTES. oDone is high between E_BYTES and E_BYTES+1. Next start can be accepted at E_BYTES+2 at the earliest.
- oBusy is high in RUN only.
- oAdd_a/b/c are 0 in IDLE and DONE.
- iStart in RUN or DONE is ignored. No queuing; the operands of the ignored request are discarded.
- oSum, oCout and oOvf change only on the RUN->DONE edge or on reset. They are stable at all other times, including during a later RUN.
- Operands may change freely after the start edge; they are not sampled again.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. The partial result is lost.
- Arithmetic is unsigned modulo 2^WIDTH; oCout is the carry out of bit WIDTH-1.

Optional Feature:
Macro SERIAL_ADD_OVF_EN.
- Defined: oOvf is registered on the RUN->DONE edge as (sa==sb) && (sum_msb!=sa). Here sa and sb are the saved operand sign bits and sum_msb is bit 7 of the final iAdd_sum. This is two's-complement signed overflow.
- Not defined: oOvf is tied to 0, the sign-bit registers are not built, and the port stays present.

Test Plan:
1. Basic add: WIDTH=32, A=0x0000000D, B=0x00000002, Cin=0, start at E0 -> oBusy high E0..E4, oDone high only E4..E5, oSum=0x0000000F, oCout=0; oAdd_a=0x0D and oAdd_b=0x02 during the first RUN cycle.
2. Byte-boundary carry: A=0x000000FF, B=0x00000001, Cin=0 -> oAdd_c=1 in the second RUN cycle, oSum=0x00000100, oCout=0.
3. Full ripple with carry-in: A=0xFFFFFFFF, B=0x00000000, Cin=1 -> oSum=0x00000000, oCout=1; oAdd_c=1 in every RUN cycle.
4. Start while busy: start A=0x0000000B, B=0x0000000B, Cin=1, then pulse iStart with A=0x55555555 one cycle later -> second request ignored, oSum=0x00000017, exactly one oDone pulse.
5. Reset mid-operation: start any operands, drop iRst_n for 1 cycle after E2 -> oBusy=0, oSum=0, oDone never pulses. A following start of 0x00000001+0x00000001 returns 0x00000002.
6. Overflow (macro defined): A=0x7FFFFFFF, B=0x00000001, Cin=0 -> oSum=0x80000000, oOvf=1, oCout=0. Without the macro, oOvf=0 for the same stimulus.
